// File: rtl/decode_stage.sv
// D stage of the 5-stage MIPS pipeline: register file, operand forwarding, early branch/jump
// resolution and the D/E pipeline register.
module decode_stage #(
  parameter bit GRF_BYPASS = 1'b1,
  parameter bit FWD_M      = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] d_instr,
  input  logic [31:0] d_pc,
  input  logic        w_we,
  input  logic [4:0]  w_addr,
  input  logic [31:0] w_data,
  input  logic        m_we,
  input  logic [4:0]  m_addr,
  input  logic [31:0] m_data,
  output logic [4:0]  d_rs,
  output logic [4:0]  d_rt,
  output logic [31:0] next_pc,
  output logic [1:0]  pc_src,
  output logic [31:0] e_instr,
  output logic [31:0] e_pc,
  output logic [31:0] e_rs_val,
  output logic [31:0] e_rt_val,
  output logic [31:0] e_imm
);

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpOri   = 6'h0d;
  localparam logic [5:0] OpLui   = 6'h0f;
  localparam logic [5:0] FnJr    = 6'h08;

  logic [31:0] r_grf [32];
  logic [31:0] r_e_instr, r_e_pc, r_e_rs_val, r_e_rt_val, r_e_imm;

  logic [5:0]  w_op, w_funct;
  logic [15:0] w_imm16;
  logic [31:0] w_sext, w_imm, w_rs_val, w_rt_val, w_pc_plus4;
  logic        w_is_beq, w_is_j, w_is_jr;

  assign w_op      = d_instr[31:26];
  assign w_funct   = d_instr[5:0];
  assign w_imm16   = d_instr[15:0];
  assign d_rs      = d_instr[25:21];
  assign d_rt      = d_instr[20:16];
  assign w_sext    = {{16{w_imm16[15]}}, w_imm16};
  assign w_pc_plus4 = d_pc + 32'd4;

  // Operand priority: $0, then M result, then W write-through, then the register file.
  function automatic logic [31:0] read_op(input logic [4:0] addr, input logic [31:0] grf_val,
                                          input logic mwe, input logic [4:0] maddr,
                                          input logic [31:0] mdata, input logic wwe,
                                          input logic [4:0] waddr, input logic [31:0] wdata);
    if (addr == 5'd0)                               return 32'd0;
    else if (FWD_M && mwe && maddr == addr)         return mdata;
    else if (GRF_BYPASS && wwe && waddr == addr)    return wdata;
    else                                            return grf_val;
  endfunction

  assign w_rs_val = read_op(d_rs, r_grf[d_rs], m_we, m_addr, m_data, w_we, w_addr, w_data);
  assign w_rt_val = read_op(d_rt, r_grf[d_rt], m_we, m_addr, m_data, w_we, w_addr, w_data);

  assign w_is_beq = (w_op == OpBeq);
  assign w_is_j   = (w_op == OpJ) || (w_op == OpJal);
  assign w_is_jr  = (w_op == OpRtype) && (w_funct == FnJr);

  always_comb begin
    unique case (w_op)
      OpOri:   w_imm = {16'h0, w_imm16};
      OpLui:   w_imm = {w_imm16, 16'h0};
      default: w_imm = w_sext;
    endcase
  end

  always_comb begin
    pc_src  = 2'b00;
    next_pc = w_pc_plus4;
    if (w_is_beq && (w_rs_val == w_rt_val)) begin
      pc_src  = 2'b01;
      next_pc = w_pc_plus4 + {w_sext[29:0], 2'b00};
    end else if (w_is_j) begin
      pc_src  = 2'b10;
      next_pc = {d_pc[31:28], d_instr[25:0], 2'b00};
    end else if (w_is_jr) begin
      pc_src  = 2'b11;
      next_pc = w_rs_val;
    end
    // F is frozen during a stall, so no redirect may be taken.
    if (stall) pc_src = 2'b00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_grf[i] <= 32'd0;
    end else if (w_we && (w_addr != 5'd0)) begin
      r_grf[w_addr] <= w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || stall) begin
      r_e_instr  <= 32'd0;
      r_e_pc     <= 32'd0;
      r_e_rs_val <= 32'd0;
      r_e_rt_val <= 32'd0;
      r_e_imm    <= 32'd0;
    end else begin
      r_e_instr  <= d_instr;
      r_e_pc     <= d_pc;
      r_e_rs_val <= w_rs_val;
      r_e_rt_val <= w_rt_val;
      r_e_imm    <= w_imm;
    end
  end

  assign e_instr  = r_e_instr;
  assign e_pc     = r_e_pc;
  assign e_rs_val = r_e_rs_val;
  assign e_rt_val = r_e_rt_val;
  assign e_imm    = r_e_imm;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: vector table for decode/redirect/D-E contents plus
// hand sequences for bypass, forwarding priority, stall and reset.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset, stall;
  logic [31:0] d_instr, d_pc;
  logic        w_we;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [4:0]  d_rs, d_rt;
  logic [31:0] next_pc;
  logic [1:0]  pc_src;
  logic [31:0] e_instr, e_pc, e_rs_val, e_rt_val, e_imm;

  int n_chk  = 0;
  int n_pass = 0;

  decode_stage #(.GRF_BYPASS(1'b1), .FWD_M(1'b1)) dut (
    .clk(clk), .reset(reset), .stall(stall), .d_instr(d_instr), .d_pc(d_pc),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .m_we(m_we), .m_addr(m_addr), .m_data(m_data),
    .d_rs(d_rs), .d_rt(d_rt), .next_pc(next_pc), .pc_src(pc_src),
    .e_instr(e_instr), .e_pc(e_pc), .e_rs_val(e_rs_val), .e_rt_val(e_rt_val), .e_imm(e_imm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        mwe;
    logic [4:0]  maddr;
    logic [31:0] mdata;
    logic        stl;
    logic        chk_npc;
    logic [1:0]  ps;
    logic [31:0] npc;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    w_we = 1'b1; w_addr = a; w_data = d;
    @(posedge clk); #1;
    w_we = 1'b0;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  initial begin
    // GRF at table time: $1=7 $2=7 $5=0x1234, everything else 0.
    vecs[0]  = '{32'h00A01821, 32'h3000,     0, 0,  0,          0, 1, 2'd0, 32'h3004,
                 32'h1234, 0, 32'h1821};
    vecs[1]  = '{32'h10220003, 32'h3000,     0, 0,  0,          0, 1, 2'd1, 32'h3010,
                 7, 7, 3};
    vecs[2]  = '{32'h10220003, 32'h3000,     1, 2,  8,          0, 1, 2'd0, 32'h3004,
                 7, 8, 3};
    vecs[3]  = '{32'h03E00008, 32'h3008,     1, 31, 32'h3040,   0, 1, 2'd3, 32'h3040,
                 32'h3040, 0, 8};
    vecs[4]  = '{32'h08000C10, 32'h3004,     0, 0,  0,          0, 1, 2'd2, 32'h3040,
                 0, 0, 32'hC10};
    vecs[5]  = '{32'h08000C10, 32'h3004,     0, 0,  0,          1, 0, 2'd0, 0,
                 0, 0, 0};
    vecs[6]  = '{32'h0C000C10, 32'hF0001000, 0, 0,  0,          0, 1, 2'd2, 32'hF0003040,
                 0, 0, 32'hC10};
    vecs[7]  = '{32'h34048000, 32'h3010,     0, 0,  0,          0, 1, 2'd0, 32'h3014,
                 0, 0, 32'h00008000};
    vecs[8]  = '{32'h3C04ABCD, 32'h3014,     0, 0,  0,          0, 1, 2'd0, 32'h3018,
                 0, 0, 32'hABCD0000};
    vecs[9]  = '{32'h8CA6FFFC, 32'h3018,     0, 0,  0,          0, 1, 2'd0, 32'h301C,
                 32'h1234, 0, 32'hFFFFFFFC};
    vecs[10] = '{32'h1000FFFF, 32'h0,        0, 0,  0,          0, 1, 2'd1, 32'h0,
                 0, 0, 32'hFFFFFFFF};
    vecs[11] = '{32'h10000002, 32'hFFFFFFF8, 0, 0,  0,          0, 1, 2'd1, 32'h4,
                 0, 0, 2};
    vecs[12] = '{32'hFC000000, 32'h100,      0, 0,  0,          0, 1, 2'd0, 32'h104,
                 0, 0, 0};
    vecs[13] = '{32'h00001821, 32'h200,      1, 0,  32'hDEAD,   0, 1, 2'd0, 32'h204,
                 0, 0, 32'h1821};

    reset = 1'b1; stall = 1'b0; d_instr = 32'd0; d_pc = 32'd0;
    w_we = 1'b0; w_addr = 5'd0; w_data = 32'd0;
    m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0;
    tick();
    reset = 1'b0;
    chk("rst_e_instr", e_instr, 0);
    chk("rst_e_pc", e_pc, 0);
    chk("rst_e_rs", e_rs_val, 0);
    chk("rst_e_rt", e_rt_val, 0);
    chk("rst_e_imm", e_imm, 0);
    chk("rst_pc_src", {30'd0, pc_src}, 0);

    for (int i = 1; i < 32; i++) begin
      d_instr = (32'(i) << 21) | (32'(i) << 16) | 32'h1821;
      tick();
      chk($sformatf("rst_grf%0d", i), e_rs_val, 0);
    end

    wr(5'd5, 32'h1234);
    wr(5'd1, 32'd7);
    wr(5'd2, 32'd7);
    wr(5'd0, 32'hFFFF);

    for (int v = 0; v < 14; v++) begin
      d_instr = vecs[v].instr; d_pc = vecs[v].pc; stall = vecs[v].stl;
      m_we = vecs[v].mwe; m_addr = vecs[v].maddr; m_data = vecs[v].mdata;
      #1;
      chk($sformatf("v%0d_pc_src", v), {30'd0, pc_src}, {30'd0, vecs[v].ps});
      if (vecs[v].chk_npc) chk($sformatf("v%0d_next_pc", v), next_pc, vecs[v].npc);
      chk($sformatf("v%0d_d_rs", v), {27'd0, d_rs}, {27'd0, vecs[v].instr[25:21]});
      chk($sformatf("v%0d_d_rt", v), {27'd0, d_rt}, {27'd0, vecs[v].instr[20:16]});
      tick();
      chk($sformatf("v%0d_e_instr", v), e_instr, vecs[v].stl ? 32'd0 : vecs[v].instr);
      chk($sformatf("v%0d_e_pc", v), e_pc, vecs[v].stl ? 32'd0 : vecs[v].pc);
      chk($sformatf("v%0d_e_rs", v), e_rs_val, vecs[v].rs);
      chk($sformatf("v%0d_e_rt", v), e_rt_val, vecs[v].rt);
      chk($sformatf("v%0d_e_imm", v), e_imm, vecs[v].imm);
    end
    stall = 1'b0; m_we = 1'b0;

    // W write-through in the same cycle, then the stored value next cycle.
    d_instr = 32'h00E01821; d_pc = 32'h400;
    w_we = 1'b1; w_addr = 5'd7; w_data = 32'h55;
    tick();
    w_we = 1'b0;
    chk("wbyp_e_rs", e_rs_val, 32'h55);
    tick();
    chk("wbyp_stored", e_rs_val, 32'h55);

    // $2=8 in the GRF: beq $1,$2 falls through.
    wr(5'd2, 32'd8);
    d_instr = 32'h10220003; d_pc = 32'h3000;
    #1;
    chk("beq_ne_pc_src", {30'd0, pc_src}, 0);
    chk("beq_ne_next_pc", next_pc, 32'h3004);

    // M beats a concurrent W write to the same register.
    d_instr = 32'h03E00008; d_pc = 32'h3008;
    w_we = 1'b1; w_addr = 5'd31; w_data = 32'h1111;
    m_we = 1'b1; m_addr = 5'd31; m_data = 32'h3040;
    #1;
    chk("mw_pc_src", {30'd0, pc_src}, 3);
    chk("mw_next_pc", next_pc, 32'h3040);
    tick();
    w_we = 1'b0; m_we = 1'b0;
    #1;
    chk("jr_grf_next_pc", next_pc, 32'h1111);

    // GRF write lands during a stall; D/E holds a bubble.
    stall = 1'b1; d_instr = 32'h01001821;
    w_we = 1'b1; w_addr = 5'd8; w_data = 32'h99;
    #1;
    chk("stall_pc_src", {30'd0, pc_src}, 0);
    tick();
    w_we = 1'b0;
    chk("stall_e_instr", e_instr, 0);
    chk("stall_e_rs", e_rs_val, 0);
    stall = 1'b0;
    tick();
    chk("stall_wr_rs", e_rs_val, 32'h99);
    chk("stall_rel_instr", e_instr, 32'h01001821);

    // Reset wins over stall and clears the GRF.
    reset = 1'b1; stall = 1'b1;
    tick();
    reset = 1'b0; stall = 1'b0;
    chk("rst2_e_instr", e_instr, 0);
    chk("rst2_e_pc", e_pc, 0);
    tick();
    chk("rst2_grf8", e_rs_val, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
